// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared register map, status bit indices and FSM states for the UART receiver
package uart_rx_pkg;

    // Register byte offsets; only address bit 2 is decoded
    localparam logic [31:0] UART_RX_DATA   = 32'h0;
    localparam logic [31:0] UART_RX_STATUS = 32'h4;

    // STATUS register bit positions
    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;

    // Receiver FSM states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - picorv32 native bus request signals towards the UART receiver
interface uart_rx_if;
    logic        enable;
    logic        mem_valid;
    logic        mem_instr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;

    modport master (output enable, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr);
    modport slave  (input  enable, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr);
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - byte FIFO with wrap-around pointers and occupancy count
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted alongside it
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign dout  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because count guards every read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - memory-mapped 8N1 UART receiver with receive FIFO and sticky error flags
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int BIT_CYCLES = CLK_HZ / BAUD,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    uart_rx_if.slave    bus,
    output wire         mem_ready,
    output wire  [31:0] mem_rdata,
    input  logic        serialIn
);
    localparam int CW = $clog2(BIT_CYCLES);

    logic          rx_meta;
    logic          rx_s;
    rx_state_t     state,  state_n;
    logic [CW-1:0] cnt,    cnt_n;
    logic [2:0]    bitidx, bitidx_n;
    logic [7:0]    shreg,  shreg_n;
    logic          rx_push;
    logic          rx_ferr;

    logic          fifo_empty;
    logic          fifo_full;
    logic [7:0]    fifo_dout;

    logic          bus_sel;
    logic          bus_acc;
    logic          bus_wr;
    logic          bus_status;
    logic          rd_pop;
    logic          ready_r;
    logic [31:0]   rdata_r;
    logic [31:0]   status_word;
    logic [31:0]   data_word;
    logic          overrun;
    logic          frame_err;
    logic          set_ovr;
    logic          clr_ovr;
    logic          clr_ferr;
    logic          unused_bits;

    assign unused_bits = &{1'b0, bus.mem_instr, bus.mem_addr[31:3], bus.mem_addr[1:0],
                           bus.mem_wdata[31:4], bus.mem_wdata[1:0]};

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= serialIn;
            rx_s    <= rx_meta;
        end
    end

    // Receiver state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            cnt    <= '0;
            bitidx <= '0;
            shreg  <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            bitidx <= bitidx_n;
            shreg  <= shreg_n;
        end
    end

    // Receiver next state: half-bit to centre on the start bit, then whole bits
    always_comb begin
        state_n  = state;
        cnt_n    = (cnt != '0) ? cnt - 1'b1 : cnt;
        bitidx_n = bitidx;
        shreg_n  = shreg;
        rx_push  = 1'b0;
        rx_ferr  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    cnt_n   = CW'(BIT_CYCLES / 2 - 1);
                    state_n = S_START;
                end
            end
            S_START: begin
                if (cnt == '0) begin
                    if (!rx_s) begin
                        cnt_n    = CW'(BIT_CYCLES - 1);
                        bitidx_n = 3'd0;
                        state_n  = S_DATA;
                    end else begin
                        state_n  = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt == '0) begin
                    shreg_n  = {rx_s, shreg[7:1]};
                    cnt_n    = CW'(BIT_CYCLES - 1);
                    bitidx_n = bitidx + 3'd1;
                    if (bitidx == 3'd7) state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt == '0) begin
                    if (rx_s) begin
                        rx_push = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        rx_ferr = 1'b1;
                        state_n = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (rx_push),
        .din    (shreg),
        .pop    (rd_pop),
        .dout   (fifo_dout),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    assign bus_sel    = bus.enable & bus.mem_valid;
    assign bus_acc    = bus_sel & ~ready_r;
    assign bus_wr     = |bus.mem_wstrb;
    assign bus_status = (bus.mem_addr[2] == UART_RX_STATUS[2]);
    assign rd_pop     = bus_acc & ~bus_wr & ~bus_status;

    // A full FIFO only drops the byte if no read is freeing a slot this cycle
    assign set_ovr  = rx_push & fifo_full & ~rd_pop;
    assign clr_ovr  = bus_acc & bus_wr & bus_status & bus.mem_wdata[ST_OVERRUN];
    assign clr_ferr = bus_acc & bus_wr & bus_status & bus.mem_wdata[ST_FRAME_ERR];

    assign data_word = fifo_empty ? 32'h0 : {23'h0, 1'b1, fifo_dout};

    // STATUS register image
    always_comb begin
        status_word               = '0;
        status_word[ST_NOT_EMPTY] = ~fifo_empty;
        status_word[ST_FULL]      = fifo_full;
        status_word[ST_OVERRUN]   = overrun;
        status_word[ST_FRAME_ERR] = frame_err;
    end

    // Sticky error flags; a new event wins over a simultaneous write-1-clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= (overrun & ~clr_ovr) | set_ovr;
            frame_err <= (frame_err & ~clr_ferr) | rx_ferr;
        end
    end

    // One-cycle acknowledge with read data captured in the same cycle as the pop
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_r <= 1'b0;
            rdata_r <= '0;
        end else begin
            ready_r <= bus_acc;
            if (bus_acc) rdata_r <= bus_wr ? 32'h0 : (bus_status ? status_word : data_word);
        end
    end

    assign mem_ready = bus_sel ? ready_r : 1'bz;
    assign mem_rdata = bus_sel ? rdata_r : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed and randomized bench for uart_rx against a queue-based reference model
module tb_uart_rx;
    localparam int B     = 16;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        serialIn = 1'b1;
    wire         mem_ready;
    wire  [31:0] mem_rdata;

    uart_rx_if bus ();

    uart_rx #(
        .CLK_HZ     (100000000),
        .BAUD       (115200),
        .BIT_CYCLES (B),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .serialIn  (serialIn)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  model_q[$];
    logic        m_ovr = 1'b0;
    logic        m_ferr = 1'b0;
    logic [31:0] rd;
    logic [31:0] exp_w;
    logic [7:0]  byte_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'h0;
        s[0] = (model_q.size() != 0);
        s[1] = (model_q.size() == DEPTH);
        s[2] = m_ovr;
        s[3] = m_ferr;
        return s;
    endfunction

    function automatic logic [31:0] model_pop();
        if (model_q.size() == 0) return 32'h0;
        return {23'h0, 1'b1, model_q.pop_front()};
    endfunction

    function automatic void model_push(input logic [7:0] d);
        if (model_q.size() < DEPTH) model_q.push_back(d);
        else m_ovr = 1'b1;
    endfunction

    // Caller is 1 time unit after a clock edge; returns likewise
    task automatic bus_access(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                              output logic [31:0] rdv);
        int n;
        bus.enable    = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wstrb = wr ? 4'hf : 4'h0;
        bus.mem_wdata = wd;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (mem_ready !== 1'b1 && n < 4);
        check("bus_ready", {31'h0, mem_ready}, 32'h1);
        rdv = mem_rdata;
        bus.enable    = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
    endtask

    task automatic read_data(input string tag);
        logic [31:0] r;
        logic [31:0] e;
        e = model_pop();
        bus_access(32'h0, 1'b0, 32'h0, r);
        check(tag, r, e);
    endtask

    task automatic read_status(input string tag);
        logic [31:0] r;
        bus_access(32'h4, 1'b0, 32'h0, r);
        check(tag, r, model_status());
    endtask

    task automatic write_status(input logic [31:0] v);
        logic [31:0] r;
        bus_access(32'h4, 1'b1, v, r);
        if (v[2]) m_ovr = 1'b0;
        if (v[3]) m_ferr = 1'b0;
    endtask

    // Drives the first nbits of a start/data/stop frame; returns 1 unit after an edge
    task automatic send_frame(input logic [7:0] d, input logic stop, input int nbits);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        @(posedge clk);
        for (int i = 0; i < nbits; i++) begin
            #1 serialIn = fr[i];
            repeat (B) @(posedge clk);
        end
        #1;
    endtask

    initial begin
        bus.enable    = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_wstrb = 4'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_addr  = 32'h0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        read_status("reset_status");
        read_data("reset_data");

        // Single byte, second read empty
        send_frame(8'h5A, 1'b1, 10);
        model_push(8'h5A);
        read_data("single_5a");
        read_data("single_empty");
        read_status("single_status");

        // Push latency: not_empty must still be low after edge 151 and high after edge 154
        fork
            send_frame(8'hA5, 1'b1, 10);
            begin
                @(posedge clk);
                repeat (152) @(posedge clk);
                #1;
                bus_access(32'h4, 1'b0, 32'h0, rd);
                check("latency_before", rd, 32'h0);
                @(posedge clk);
                @(posedge clk);
                #1;
                bus_access(32'h4, 1'b0, 32'h0, rd);
                check("latency_after", rd, 32'h1);
            end
        join
        model_push(8'hA5);
        read_data("latency_a5");

        // Short glitch is rejected
        @(posedge clk);
        #1 serialIn = 1'b0;
        repeat (4) @(posedge clk);
        #1 serialIn = 1'b1;
        repeat (3 * B) @(posedge clk);
        #1;
        read_status("glitch_status");

        // Framing error followed by a held-low line
        send_frame(8'h33, 1'b0, 10);
        m_ferr = 1'b1;
        repeat (200) @(posedge clk);
        #1 serialIn = 1'b1;
        repeat (2 * B) @(posedge clk);
        #1;
        read_status("ferr_status");
        read_data("ferr_empty");
        write_status(32'h8);
        read_status("ferr_cleared");

        // Overrun on the 17th byte
        for (int i = 0; i < DEPTH + 1; i++) begin
            send_frame(8'(i), 1'b1, 10);
            model_push(8'(i));
        end
        read_status("ovr_status");
        for (int i = 0; i < DEPTH; i++) read_data("ovr_drain");
        read_status("ovr_after_drain");
        write_status(32'h4);
        read_status("ovr_cleared");

        // Pop coinciding with a push into a full FIFO
        for (int i = 0; i < DEPTH; i++) begin
            byte_v = 8'($urandom);
            send_frame(byte_v, 1'b1, 10);
            model_push(byte_v);
        end
        byte_v = 8'($urandom);
        exp_w  = model_pop();
        fork
            send_frame(byte_v, 1'b1, 10);
            begin
                @(posedge clk);
                repeat (154) @(posedge clk);
                #1;
                bus_access(32'h0, 1'b0, 32'h0, rd);
            end
        join
        model_push(byte_v);
        check("conc_pop", rd, exp_w);
        read_status("conc_status");
        for (int i = 0; i < DEPTH; i++) read_data("conc_drain");

        // Random bytes with interleaved reads
        for (int i = 0; i < 10; i++) begin
            byte_v = 8'($urandom);
            send_frame(byte_v, 1'b1, 10);
            model_push(byte_v);
            if ($urandom_range(0, 1) == 1) read_data("rand_read");
        end
        read_status("rand_status");
        while (model_q.size() != 0) read_data("rand_drain");
        read_status("rand_final");

        // Reset in the middle of the data bits
        send_frame(8'h11, 1'b1, 10);
        model_push(8'h11);
        write_status(32'h0);
        send_frame(8'h5A, 1'b1, 5);
        resetn = 1'b0;
        serialIn = 1'b1;
        model_q.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (2 * B) @(posedge clk);
        #1;
        read_status("rst_status");
        read_data("rst_empty");
        send_frame(8'hC3, 1'b1, 10);
        model_push(8'hC3);
        read_data("rst_c3");
        read_status("rst_final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
